// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch front end: FSM encoding and fetch constants.
package fetch_unit_pkg;

    // BOOT: nothing in flight yet; RUN: last request is correct-path;
    // KILL: last request is wrong-path and its data must be dropped.
    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_KILL = 2'd2
    } fetch_state_e;

    localparam logic [31:0] FETCH_NOP_INSN = 32'h0000_0013;
    localparam int          FETCH_PC_INC   = 4;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit and the memory.
// Handshake: imem_en is the request valid; the memory is always ready and
// returns imem_rdata for the address presented on the following cycle.
interface fetch_unit_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INSN_WIDTH = 32
);
    logic                  imem_en;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic [INSN_WIDTH-1:0] imem_rdata;

    modport master (output imem_en, output imem_addr, input imem_rdata);
    modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats capture.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int                    PC_WIDTH   = 32,
    parameter int                    INSN_WIDTH = 32,
    parameter logic [INSN_WIDTH-1:0] NOP_INSN   = INSN_WIDTH'(FETCH_NOP_INSN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  stall_i,
    input  logic                  valid_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    input  logic [INSN_WIDTH-1:0] insn_i,
    output logic                  valid_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [INSN_WIDTH-1:0] insn_o
);
    logic                  valid_q, valid_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [INSN_WIDTH-1:0] insn_q, insn_d;

    // Next-state selection; a flushed entry keeps its PC but becomes a NOP bubble.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        if (flush_i) begin
            valid_d = 1'b0;
            insn_d  = NOP_INSN;
        end else if (!stall_i) begin
            valid_d = valid_i;
            pc_d    = pc_i;
            insn_d  = valid_i ? insn_i : NOP_INSN;
        end
    end

    // Register with asynchronous reset to an invalid NOP entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            insn_q  <= NOP_INSN;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign insn_o  = insn_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, instruction-memory request stage and IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    PC_WIDTH   = 32,
    parameter int                    INSN_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = PC_WIDTH'(FETCH_RESET_PC),
    parameter logic [INSN_WIDTH-1:0] NOP_INSN   = INSN_WIDTH'(FETCH_NOP_INSN),
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pc_stall,
    input  logic                  if_stall,
    input  logic                  if_flush,
    input  logic                  jp_taken,
    input  logic [PC_WIDTH-1:0]   jp_target,
    input  logic                  br_taken,
    input  logic [PC_WIDTH-1:0]   br_target,
    fetch_unit_if.master          imem,
    output logic                  if_en,
    output logic                  id_valid,
    output logic [PC_WIDTH-1:0]   id_pc,
    output logic [INSN_WIDTH-1:0] id_insn,
    output logic [CNT_WIDTH-1:0]  redirect_cnt,
    output fetch_state_e          dbg_state
);
    fetch_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   req_pc_q, req_pc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  redir;
    logic [PC_WIDTH-1:0]   redir_target;

    assign redir        = br_taken | jp_taken;
    // The ROB branch is older than the decoder jump, so it wins.
    assign redir_target = br_taken ? br_target : jp_target;

    // Next PC, in-flight request tracking and redirect counting.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        cnt_d    = cnt_q;
        if (redir) begin
            // Redirect overrides pc_stall; the request issued this cycle is wrong-path.
            pc_d    = redir_target;
            state_d = FETCH_KILL;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
        end else begin
            if (!pc_stall) begin
                pc_d     = pc_q + PC_WIDTH'(FETCH_PC_INC);
                req_pc_d = pc_q;
                state_d  = FETCH_RUN;
            end else if (state_q == FETCH_BOOT) begin
                // RESET_PC is already on the bus, so its data arrives next cycle.
                state_d = FETCH_RUN;
            end
            if (if_flush) begin
                state_d = FETCH_KILL;
            end
        end
    end

    // State, PC and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH_BOOT;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            cnt_q    <= cnt_d;
        end
    end

    // A read is issued every cycle out of reset; a stalled PC simply re-reads.
    assign imem.imem_en   = rst_n;
    assign imem.imem_addr = pc_q;
    assign if_en          = (state_q == FETCH_RUN);
    assign redirect_cnt   = cnt_q;
    assign dbg_state      = state_q;

    if_id_reg #(
        .PC_WIDTH   (PC_WIDTH),
        .INSN_WIDTH (INSN_WIDTH),
        .NOP_INSN   (NOP_INSN)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (if_flush),
        .stall_i (if_stall),
        .valid_i (if_en),
        .pc_i    (req_pc_q),
        .insn_i  (imem.imem_rdata),
        .valid_o (id_valid),
        .pc_o    (id_pc),
        .insn_o  (id_insn)
    );
endmodule
